// File: rtl/dist_pkg.sv
// dist_pkg: shared types and constants for the distortion control plane.
//   dist_ctrl_state_t : mode-change FSM states (IDLE, FADE_OUT, SWITCH, FADE_IN)
//   DEFAULT_STEP      : default threshold slew per sample tick
//   DEFAULT_FADE_SHIFT: default log2 of the fade length in ticks
//   gain_width()      : width needed to hold gain 0 .. 2^fade_shift
package dist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWITCH   = 2'd2,
        ST_FADE_IN  = 2'd3
    } dist_ctrl_state_t;

    localparam int DEFAULT_STEP       = 64;
    localparam int DEFAULT_FADE_SHIFT = 6;

    // Full-scale gain is 2^fade_shift, which needs one bit more than fade_shift.
    function automatic int gain_width(input int fade_shift);
        return fade_shift + 1;
    endfunction

endpackage

// File: rtl/slew_limiter.sv
// slew_limiter: moves a registered value toward a target by at most STEP per
// enabled cycle, landing exactly on the target once within reach.
//   clk, rst : clock, synchronous active-high reset (value <- RESET_VAL)
//   en       : advance strobe; value holds when low
//   target   : signed destination, re-read every enabled cycle
//   value    : signed registered output
module slew_limiter #(
    parameter int                      WIDTH     = 16,
    parameter int                      STEP      = 64,
    parameter logic signed [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] target,
    output logic signed [WIDTH-1:0] value
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam logic [WIDTH:0]   STEP_WIDE   = W1'(STEP);
    localparam logic [WIDTH-1:0] STEP_NARROW = WIDTH'(STEP);

    logic signed [WIDTH-1:0] value_q, value_d;
    logic signed [WIDTH:0]   diff;
    logic        [WIDTH:0]   mag;

    // One extra bit keeps target - value from wrapping for any pair of inputs.
    always_comb begin
        value_d = value_q;
        diff    = {target[WIDTH-1], target} - {value_q[WIDTH-1], value_q};
        mag     = diff[WIDTH] ? -diff : diff;
        if (en) begin
            if (mag <= STEP_WIDE) begin
                value_d = target;
            end else if (diff[WIDTH]) begin
                value_d = value_q - STEP_NARROW;
            end else begin
                value_d = value_q + STEP_NARROW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= RESET_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/distortion_ctrl.sv
// distortion_ctrl: control-plane sequencer for the distortion datapath.
// Slew-limits threshold changes and wraps mode changes in a fade-out /
// switch / fade-in gain envelope so that control changes do not click.
//   clk, rst      : clock, synchronous active-high reset
//   sample_tick   : one-cycle strobe per audio sample; all state advances only here
//   thresh_req    : requested threshold (signed, negatives clamp to 0)
//   softclip_req  : requested mode (1 = soft clip)
//   threshold_out : slewed threshold to the datapath
//   softclip_out  : mode to the datapath
//   gain_out      : envelope 0 .. 2^FADE_SHIFT for the downstream multiplier
//   busy          : a ramp or fade is in progress
// Optional build macro DIST_CTRL_BYPASS_EN adds bypass_req / bypass_out, which
// switch under the same fade as the mode.
module distortion_ctrl
    import dist_pkg::*;
#(
    parameter int                      WIDTH        = 16,
    parameter int                      STEP         = DEFAULT_STEP,
    parameter int                      FADE_SHIFT   = DEFAULT_FADE_SHIFT,
    parameter logic signed [WIDTH-1:0] RESET_THRESH = 16'sh4000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_tick,
    input  logic signed [WIDTH-1:0]        thresh_req,
    input  logic                           softclip_req,
    output logic signed [WIDTH-1:0]        threshold_out,
    output logic                           softclip_out,
    output logic [gain_width(FADE_SHIFT)-1:0] gain_out,
    output logic                           busy
`ifdef DIST_CTRL_BYPASS_EN
    ,
    input  logic                           bypass_req,
    output logic                           bypass_out
`endif
);

    localparam int GW = gain_width(FADE_SHIFT);
    localparam logic [GW-1:0] GAIN_FULL = {1'b1, {FADE_SHIFT{1'b0}}};
    localparam logic [GW-1:0] GAIN_ONE  = GW'(1);

    logic signed [WIDTH-1:0] tgt;
    dist_ctrl_state_t        state_q, state_d;
    logic [GW-1:0]           gain_q, gain_d;
    logic                    softclip_q, softclip_d;
    logic                    pend_soft_q, pend_soft_d;
    logic                    mismatch;

    // Negative requests are meaningless for a clip level, so they pin to zero.
    assign tgt = thresh_req[WIDTH-1] ? '0 : thresh_req;

    slew_limiter #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .RESET_VAL(RESET_THRESH)
    ) u_slew (
        .clk   (clk),
        .rst   (rst),
        .en    (sample_tick),
        .target(tgt),
        .value (threshold_out)
    );

`ifdef DIST_CTRL_BYPASS_EN
    logic bypass_q, bypass_d;
    logic pend_byp_q, pend_byp_d;
    assign mismatch = (softclip_req != softclip_q) || (bypass_req != bypass_q);
`else
    assign mismatch = (softclip_req != softclip_q);
`endif

    // Mode FSM. A fade that is abandoned in FADE_OUT turns around in place,
    // and FADE_IN refuses to climb past full scale in case it was entered at
    // full gain by an immediate abort.
    always_comb begin
        state_d     = state_q;
        gain_d      = gain_q;
        softclip_d  = softclip_q;
        pend_soft_d = pend_soft_q;
`ifdef DIST_CTRL_BYPASS_EN
        bypass_d    = bypass_q;
        pend_byp_d  = pend_byp_q;
`endif
        if (sample_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (mismatch) begin
                        pend_soft_d = softclip_req;
`ifdef DIST_CTRL_BYPASS_EN
                        pend_byp_d  = bypass_req;
`endif
                        state_d     = ST_FADE_OUT;
                    end
                end
                ST_FADE_OUT: begin
                    if (!mismatch) begin
                        state_d = ST_FADE_IN;
                    end else begin
                        gain_d = gain_q - GAIN_ONE;
                        if (gain_q == GAIN_ONE) begin
                            state_d = ST_SWITCH;
                        end
                    end
                end
                ST_SWITCH: begin
                    softclip_d = pend_soft_q;
`ifdef DIST_CTRL_BYPASS_EN
                    bypass_d   = pend_byp_q;
`endif
                    state_d    = ST_FADE_IN;
                end
                ST_FADE_IN: begin
                    if (gain_q >= GAIN_FULL) begin
                        state_d = ST_IDLE;
                    end else begin
                        gain_d = gain_q + GAIN_ONE;
                        if (gain_q == GAIN_FULL - GAIN_ONE) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gain_q      <= GAIN_FULL;
            softclip_q  <= 1'b0;
            pend_soft_q <= 1'b0;
`ifdef DIST_CTRL_BYPASS_EN
            bypass_q    <= 1'b0;
            pend_byp_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            softclip_q  <= softclip_d;
            pend_soft_q <= pend_soft_d;
`ifdef DIST_CTRL_BYPASS_EN
            bypass_q    <= bypass_d;
            pend_byp_q  <= pend_byp_d;
`endif
        end
    end

    assign softclip_out = softclip_q;
    assign gain_out     = gain_q;
    assign busy         = (state_q != ST_IDLE) || (threshold_out != tgt);
`ifdef DIST_CTRL_BYPASS_EN
    assign bypass_out   = bypass_q;
`endif

endmodule

// File: tb/tb_distortion_ctrl.sv
// tb_distortion_ctrl: self-checking bench for distortion_ctrl (default build,
// bypass feature disabled).
module tb_distortion_ctrl;

    localparam int STEP  = 64;
    localparam int FULL  = 64;
    localparam int RTHR  = 16'h4000;

    localparam int PH_IDLE = 0;
    localparam int PH_DOWN = 1;
    localparam int PH_SWAP = 2;
    localparam int PH_UP   = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               sample_tick = 1'b0;
    logic signed [15:0] thresh_req = 16'sh4000;
    logic               softclip_req = 1'b0;
    logic signed [15:0] threshold_out;
    logic               softclip_out;
    logic [6:0]         gain_out;
    logic               busy;

    int checks = 0;
    int failures = 0;

    int m_thr, m_gain, m_soft, m_pend, m_phase;

    distortion_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .thresh_req   (thresh_req),
        .softclip_req (softclip_req),
        .threshold_out(threshold_out),
        .softclip_out (softclip_out),
        .gain_out     (gain_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int model_target();
        return (thresh_req < 0) ? 0 : int'(thresh_req);
    endfunction

    function automatic void model_reset();
        m_thr   = RTHR;
        m_gain  = FULL;
        m_soft  = 0;
        m_pend  = 0;
        m_phase = PH_IDLE;
    endfunction

    function automatic void model_step();
        int t, d, req;
        t = model_target();
        d = t - m_thr;
        if (d <= STEP && d >= -STEP) m_thr = t;
        else if (d > 0)              m_thr = m_thr + STEP;
        else                         m_thr = m_thr - STEP;
        req = int'(softclip_req);
        case (m_phase)
            PH_IDLE: if (req != m_soft) begin
                m_pend  = req;
                m_phase = PH_DOWN;
            end
            PH_DOWN: if (req == m_soft) begin
                m_phase = PH_UP;
            end else begin
                m_gain = m_gain - 1;
                if (m_gain == 0) m_phase = PH_SWAP;
            end
            PH_SWAP: begin
                m_soft  = m_pend;
                m_phase = PH_UP;
            end
            default: begin
                if (m_gain < FULL) m_gain = m_gain + 1;
                if (m_gain == FULL) m_phase = PH_IDLE;
            end
        endcase
    endfunction

    function automatic int model_busy();
        return (m_phase != PH_IDLE || m_thr != model_target()) ? 1 : 0;
    endfunction

    task automatic tick();
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        model_step();
    endtask

    task automatic do_reset(input logic with_tick);
        @(negedge clk);
        rst = 1'b1;
        sample_tick = with_tick;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample_tick = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        thresh_req   = 16'sh4000;
        softclip_req = 1'b0;
        do_reset(1'b0);
        checks++;
        if (int'(threshold_out) !== RTHR) begin
            failures++;
            $display("[TB] FAIL reset_thr: got %0h want %0h", threshold_out, RTHR);
        end
        checks++;
        if (softclip_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_soft: got %0b want 0", softclip_out);
        end
        checks++;
        if (int'(gain_out) !== FULL) begin
            failures++;
            $display("[TB] FAIL reset_gain: got %0d want %0d", gain_out, FULL);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %0b want 0", busy);
        end
        thresh_req   = 16'sh4100;
        softclip_req = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (int'(threshold_out) !== RTHR || softclip_out !== 1'b0 || int'(gain_out) !== FULL) begin
            failures++;
            $display("[TB] FAIL hold_no_tick: got thr=%0h soft=%0b gain=%0d want thr=%0h soft=0 gain=%0d",
                     threshold_out, softclip_out, gain_out, RTHR, FULL);
        end
        thresh_req   = 16'sh4000;
        softclip_req = 1'b0;
    endtask

    task automatic test_ramp_up();
        int exp_vals[4] = '{16'h4040, 16'h4080, 16'h40C0, 16'h4100};
        thresh_req = 16'sh4100;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (int'(threshold_out) !== exp_vals[i] || int'(threshold_out) !== m_thr) begin
                failures++;
                $display("[TB] FAIL ramp_tick%0d: got %0h want %0h", i + 1, threshold_out, exp_vals[i]);
            end
            checks++;
            if (busy !== ((i == 3) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("[TB] FAIL ramp_busy%0d: got %0b want %0b", i + 1, busy, (i != 3));
            end
        end
    endtask

    task automatic test_clamp();
        int n = 0;
        thresh_req = 16'sh0050;
        while (m_thr != 16'h0050 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (int'(threshold_out) !== 16'h0050) begin
            failures++;
            $display("[TB] FAIL clamp_setup: got %0h want 50", threshold_out);
        end
        thresh_req = -16'sd5;
        tick();
        checks++;
        if (int'(threshold_out) !== 16'h0010) begin
            failures++;
            $display("[TB] FAIL clamp_tick1: got %0h want 10", threshold_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (int'(threshold_out) !== 0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL clamp_floor%0d: got thr=%0h busy=%0b want thr=0 busy=0",
                         i, threshold_out, busy);
            end
        end
    endtask

    task automatic test_toggle();
        softclip_req = 1'b1;
        for (int k = 0; k <= 129; k++) begin
            tick();
            checks++;
            if (int'(gain_out) !== m_gain || int'(softclip_out) !== m_soft) begin
                failures++;
                $display("[TB] FAIL toggle_tick%0d: got gain=%0d soft=%0b want gain=%0d soft=%0d",
                         k, gain_out, softclip_out, m_gain, m_soft);
            end
            if (k == 64) begin
                checks++;
                if (gain_out !== 7'd0 || softclip_out !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL toggle_bottom: got gain=%0d soft=%0b want gain=0 soft=0",
                             gain_out, softclip_out);
                end
            end
            if (k == 65) begin
                checks++;
                if (softclip_out !== 1'b1 || gain_out !== 7'd0) begin
                    failures++;
                    $display("[TB] FAIL toggle_flip: got soft=%0b gain=%0d want soft=1 gain=0",
                             softclip_out, gain_out);
                end
            end
            if (k == 128) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL toggle_busy128: got %0b want 1", busy);
                end
            end
            if (k == 129) begin
                checks++;
                if (int'(gain_out) !== FULL || busy !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL toggle_end: got gain=%0d busy=%0b want gain=64 busy=0",
                             gain_out, busy);
                end
            end
        end
    endtask

    task automatic test_abort();
        thresh_req   = 16'sh4000;
        softclip_req = 1'b0;
        do_reset(1'b0);
        softclip_req = 1'b1;
        for (int k = 0; k <= 10; k++) tick();
        checks++;
        if (gain_out !== 7'd54) begin
            failures++;
            $display("[TB] FAIL abort_depth: got %0d want 54", gain_out);
        end
        softclip_req = 1'b0;
        tick();
        checks++;
        if (gain_out !== 7'd54) begin
            failures++;
            $display("[TB] FAIL abort_turn: got %0d want 54", gain_out);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (int'(gain_out) !== 55 + i || softclip_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL abort_rise%0d: got gain=%0d soft=%0b want gain=%0d soft=0",
                         i, gain_out, softclip_out, 55 + i);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_idle: got busy=%0b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_fade();
        softclip_req = 1'b1;
        for (int k = 0; k <= 34; k++) tick();
        checks++;
        if (gain_out !== 7'd30) begin
            failures++;
            $display("[TB] FAIL midfade_depth: got %0d want 30", gain_out);
        end
        softclip_req = 1'b0;
        do_reset(1'b1);
        checks++;
        if (int'(gain_out) !== FULL || softclip_out !== 1'b0 || busy !== 1'b0 || int'(threshold_out) !== RTHR) begin
            failures++;
            $display("[TB] FAIL midfade_reset: got gain=%0d soft=%0b busy=%0b thr=%0h want 64/0/0/4000",
                     gain_out, softclip_out, busy, threshold_out);
        end
        tick();
        checks++;
        if (int'(gain_out) !== FULL || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midfade_after: got gain=%0d busy=%0b want 64/0", gain_out, busy);
        end
    endtask

    task automatic test_random();
        logic [15:0] r;
        int gap;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(9) == 0) begin
                r = 16'($urandom);
                if ($urandom_range(1) == 0) thresh_req = $signed(r);
                else thresh_req = 16'(m_thr + int'($urandom_range(400)) - 200);
            end
            if ($urandom_range(29) == 0) softclip_req = ~softclip_req;
            gap = int'($urandom_range(2));
            if (gap > 0) begin
                repeat (gap) @(negedge clk);
                checks++;
                if (int'(threshold_out) !== m_thr || int'(gain_out) !== m_gain) begin
                    failures++;
                    $display("[TB] FAIL rand_hold%0d: got thr=%0h gain=%0d want thr=%0h gain=%0d",
                             it, threshold_out, gain_out, m_thr, m_gain);
                end
            end
            tick();
            checks++;
            if (int'(threshold_out) !== m_thr || int'(gain_out) !== m_gain ||
                int'(softclip_out) !== m_soft || int'(busy) !== model_busy()) begin
                failures++;
                $display("[TB] FAIL rand_tick%0d: got thr=%0h gain=%0d soft=%0b busy=%0b want thr=%0h gain=%0d soft=%0d busy=%0d",
                         it, threshold_out, gain_out, softclip_out, busy, m_thr, m_gain, m_soft, model_busy());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ramp_up();
        test_clamp();
        test_toggle();
        test_abort();
        test_reset_mid_fade();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
